// File: rtl/arbitro_memoria_tabuleiro.sv
// Fixed-priority arbiter between board clients and the per-player board RAMs.
// Grants carry a minimum tenure before higher-priority preemption, every
// handover passes through a one-cycle bubble, and read data is returned
// through a tagged pipeline so it reaches its requester even after the
// grant has moved on.
//
// Protocol: a client raises req[k] (level) with its we/player/addr/wdata
// and keeps them valid while it wants service; every cycle in which
// gnt[k] & req[k] is high is exactly one memory access for client k.
// Dropping req[k] ends the tenure. Read results come back later as a
// single-cycle rd_valid[k] pulse with rd_data, in issue order, and the
// client must accept them unconditionally (there is no back-pressure).
module arbitro_memoria_tabuleiro #(
  parameter int N_CLIENTS = 4,
  parameter int N_PLAYERS = 2,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int HOLD_MIN  = 12,
  parameter int MEM_LAT   = 1,
  localparam int PSEL_W   = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          resetGeral,
  input  logic [N_CLIENTS-1:0]          req,
  input  logic [N_CLIENTS-1:0]          req_we,
  input  logic [N_CLIENTS*PSEL_W-1:0]   req_player,
  input  logic [N_CLIENTS*ADDR_W-1:0]   req_addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   req_wdata,
  output logic [N_CLIENTS-1:0]          gnt,
  output logic [N_CLIENTS-1:0]          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          err,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [N_PLAYERS-1:0]          mem_wren,
  input  logic [N_PLAYERS*DATA_W-1:0]   mem_rdata
);

  localparam int CIDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TEN_W  = (HOLD_MIN > 0) ? $clog2(HOLD_MIN + 1) : 1;
  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(HOLD_MIN);
  localparam int LAST   = MEM_LAT - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CIDX_W-1:0]   owner_q, owner_d;
  logic [TEN_W-1:0]    tenure_q;
  logic [CIDX_W-1:0]   low_idx;
  logic                any_req, hi_req;

  logic                access;
  logic                sel_we, sel_oor;
  logic [PSEL_W-1:0]   sel_player;
  logic [ADDR_W-1:0]   sel_addr, addr_q;
  logic [DATA_W-1:0]   sel_wdata, wdata_q;

  // Read tags in flight: valid, requester, player, out-of-range flag.
  logic [MEM_LAT-1:0]              pipe_v;
  logic [MEM_LAT-1:0][CIDX_W-1:0]  pipe_c;
  logic [MEM_LAT-1:0][PSEL_W-1:0]  pipe_p;
  logic [MEM_LAT-1:0]              pipe_oor;

  assign any_req = |req;

  // Lowest pending index and whether anyone above the current owner is waiting.
  always_comb begin
    low_idx = '0;
    hi_req  = 1'b0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) low_idx = CIDX_W'(i);
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (req[i] && (i < int'(owner_q))) hi_req = 1'b1;
    end
  end

  // Next-state logic: grant, hold for tenure, bubble on every handover.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
          owner_d = low_idx;
        end
      end
      S_GRANT: begin
        if (!req[owner_q] || ((tenure_q >= TEN_MAX) && hi_req)) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        if (any_req) begin
          state_d = S_GRANT;
          owner_d = low_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, owner, registered grant and saturating tenure counter.
  always_ff @(posedge clk) begin
    if (resetGeral) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      tenure_q <= '0;
      gnt      <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt     <= (state_d == S_GRANT) ? (N_CLIENTS'(1) << owner_d) : '0;
      if (state_d == S_GRANT) begin
        if (state_q != S_GRANT)     tenure_q <= TEN_W'(1);
        else if (tenure_q < TEN_MAX) tenure_q <= tenure_q + TEN_W'(1);
      end else begin
        tenure_q <= '0;
      end
    end
  end

  // Fields of the client currently owning the grant.
  assign access     = |(gnt & req);
  assign sel_we     = req_we[owner_q];
  assign sel_player = req_player[int'(owner_q)*PSEL_W +: PSEL_W];
  assign sel_addr   = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign sel_wdata  = req_wdata[int'(owner_q)*DATA_W +: DATA_W];
  assign sel_oor    = (int'(sel_player) >= N_PLAYERS);

  // The shared bus follows the active client and parks on its last value.
  assign mem_addr  = resetGeral ? '0 : (access ? sel_addr  : addr_q);
  assign mem_wdata = resetGeral ? '0 : (access ? sel_wdata : wdata_q);

  // Write strobe only for the addressed, in-range player.
  always_comb begin
    mem_wren = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      mem_wren[p] = access && sel_we && !resetGeral && (int'(sel_player) == p);
    end
  end

  // Remember the last driven bus values and flag out-of-range accesses.
  always_ff @(posedge clk) begin
    if (resetGeral) begin
      addr_q  <= '0;
      wdata_q <= '0;
      err     <= 1'b0;
    end else begin
      err <= access && sel_oor;
      if (access) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

  // Tagged read-return pipeline; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (resetGeral) begin
      pipe_v   <= '0;
      pipe_c   <= '0;
      pipe_p   <= '0;
      pipe_oor <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      pipe_v[0]   <= access && !sel_we;
      pipe_c[0]   <= owner_q;
      pipe_p[0]   <= sel_player;
      pipe_oor[0] <= sel_oor;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_c[i]   <= pipe_c[i-1];
        pipe_p[i]   <= pipe_p[i-1];
        pipe_oor[i] <= pipe_oor[i-1];
      end
      rd_valid <= pipe_v[LAST] ? (N_CLIENTS'(1) << pipe_c[LAST]) : '0;
      if (pipe_v[LAST]) begin
        rd_data <= pipe_oor[LAST] ? '0 : mem_rdata[int'(pipe_p[LAST])*DATA_W +: DATA_W];
      end
    end
  end

endmodule
